// File: rtl/srt4_prenorm_pipe_pkg.sv
// Shared constants, width helpers and sign-info bundle for the SRT-4 divider
// front end (pre-normaliser, iteration core and post-processing).
package srt4_prenorm_pipe_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int STAR_PAD   = 3;

  typedef struct packed {
    logic quo_neg;
    logic rem_neg;
  } sign_info_t;

  function automatic int itw_of(input int dw);
    return $clog2(dw / 2 + 2);
  endfunction

  function automatic int rw_of(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/srt4_prenorm_pipe_if.sv
// Operand/result bundle between the operand source, the pre-normaliser and
// the iteration core.
interface srt4_prenorm_pipe_if #(
  parameter int DW = srt4_prenorm_pipe_pkg::DW_DEFAULT
);
  localparam int ITW = srt4_prenorm_pipe_pkg::itw_of(DW);
  localparam int RW  = srt4_prenorm_pipe_pkg::rw_of(DW);

  // A bundle moves on a cycle where valid and ready are both high at the
  // clock edge; a producer holding valid must keep its bundle stable until then.
  logic          in_valid;
  logic          in_ready;
  logic          op_signed;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;

  logic          out_valid;
  logic          out_ready;
  logic [DW+2:0] divisor_star;
  logic [DW+5:0] dividend_star;
  logic [ITW-1:0] iterations;
  logic [RW-1:0] recovery;
  logic          quo_neg;
  logic          rem_neg;
  logic          div_by_zero;

  modport master (
    output in_valid, op_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, divisor_star, dividend_star, iterations,
           recovery, quo_neg, rem_neg, div_by_zero
  );

  modport slave (
    input  in_valid, op_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, divisor_star, dividend_star, iterations,
           recovery, quo_neg, rem_neg, div_by_zero
  );

endinterface

// File: rtl/srt4_lzc.sv
// Combinational leading-zero counter built as a binary tree of 2-bit encoders.
module srt4_lzc #(
  parameter int DW  = 32,
  parameter int LZW = $clog2(DW)
) (
  input  logic [DW-1:0]  a,
  output logic [LZW-1:0] lz,
  output logic           all_zero
);

  localparam int NP = 1 << LZW;

  logic [NP-1:0]  v_l [LZW+1];
  logic [LZW-1:0] c_l [LZW+1][NP];

  // Operand is left-justified into a power-of-two field; zero padding at the
  // bottom never changes the count for a non-zero operand.
  always_comb begin
    for (int k = 0; k <= LZW; k++) begin
      v_l[k] = '0;
      for (int j = 0; j < NP; j++) c_l[k][j] = '0;
    end
    v_l[0] = NP'(a) << (NP - DW);
    for (int k = 1; k <= LZW; k++) begin
      for (int j = 0; j < (NP >> k); j++) begin
        v_l[k][j] = v_l[k-1][2*j+1] | v_l[k-1][2*j];
        c_l[k][j] = v_l[k-1][2*j+1] ? c_l[k-1][2*j+1]
                                    : (c_l[k-1][2*j] | LZW'(1 << (k - 1)));
      end
    end
  end

  assign lz       = c_l[LZW][0];
  assign all_zero = ~v_l[LZW][0];

endmodule

// File: rtl/srt4_prenorm_pipe.sv
// Two-stage SRT-4 pre-normaliser: S1 takes magnitudes and signs, S2 normalises
// the divisor, aligns the dividend and derives iteration/recovery counts.
module srt4_prenorm_pipe
  import srt4_prenorm_pipe_pkg::*;
#(
  parameter int DW        = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  srt4_prenorm_pipe_if.slave io
);

  localparam int ITW = itw_of(DW);
  localparam int RW  = rw_of(DW);
  localparam int LZW = $clog2(DW);

  logic s1_valid, s2_valid, s1_adv, s2_adv;

  logic op_sgn, sgn_dd, sgn_dv;
  logic [DW-1:0] abs_dd, abs_dv;
  sign_info_t    in_sign;

  logic [DW-1:0] s1_abs_dd, s1_abs_dv;
  sign_info_t    s1_sign;

  logic [LZW-1:0] lz;
  logic           dv_zero;
  logic [DW-1:0]  dv_norm;
  logic [DW+2:0]  dd_align;
  logic [ITW-1:0] iter_n;
  logic [RW-1:0]  rec_n;

  logic [DW+2:0]  dv_star_q;
  logic [DW+5:0]  dd_star_q;
  logic [ITW-1:0] iter_q;
  logic [RW-1:0]  rec_q;
  sign_info_t     s2_sign;
  logic           dbz_q;

  // Each stage moves when its successor can take the entry; ready never
  // depends on in_valid, only on occupancy and out_ready.
  assign s2_adv      = ~s2_valid | io.out_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign io.in_ready = ~rst & s1_adv;

  always_comb begin
    op_sgn          = io.op_signed & SIGNED_EN;
    sgn_dd          = op_sgn & io.dividend[DW-1];
    sgn_dv          = op_sgn & io.divisor[DW-1];
    abs_dd          = sgn_dd ? -io.dividend : io.dividend;
    abs_dv          = sgn_dv ? -io.divisor  : io.divisor;
    in_sign.quo_neg = op_sgn & (sgn_dd ^ sgn_dv) & (|io.divisor);
    in_sign.rem_neg = op_sgn & sgn_dd & (|io.dividend);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_abs_dd <= '0;
      s1_abs_dv <= '0;
      s1_sign   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_abs_dd <= abs_dd;
        s1_abs_dv <= abs_dv;
        s1_sign   <= in_sign;
      end
    end
  end

  srt4_lzc #(.DW(DW), .LZW(LZW)) u_lzc (
    .a        (s1_abs_dv),
    .lz       (lz),
    .all_zero (dv_zero)
  );

  // Odd lz leaves the dividend as is; even lz shifts it one more place so the
  // quotient digits land on a radix-4 boundary.
  always_comb begin
    dv_norm  = s1_abs_dv << lz;
    dd_align = lz[0] ? {3'b000, s1_abs_dd} : {2'b00, s1_abs_dd, 1'b0};
    iter_n   = ITW'((int'(lz) + 1) / 2 + 1);
    rec_n    = RW'(DW - int'(lz));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      dv_star_q <= '0;
      dd_star_q <= '0;
      iter_q    <= '0;
      rec_q     <= '0;
      s2_sign   <= '0;
      dbz_q     <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        dbz_q     <= dv_zero;
        dv_star_q <= dv_zero ? '0 : {3'b000, dv_norm};
        dd_star_q <= dv_zero ? '0 : {3'b000, dd_align};
        iter_q    <= dv_zero ? '0 : iter_n;
        rec_q     <= dv_zero ? '0 : rec_n;
        s2_sign   <= dv_zero ? '0 : s1_sign;
      end
    end
  end

  assign io.out_valid     = s2_valid;
  assign io.divisor_star  = dv_star_q;
  assign io.dividend_star = dd_star_q;
  assign io.iterations    = iter_q;
  assign io.recovery      = rec_q;
  assign io.quo_neg       = s2_sign.quo_neg;
  assign io.rem_neg       = s2_sign.rem_neg;
  assign io.div_by_zero   = dbz_q;

endmodule

// File: tb/tb_srt4_prenorm_pipe.sv
// Bench for srt4_prenorm_pipe (DW=32): directed spec cases, random traffic with
// random back-pressure, stall/flush/reset scenarios, checked against a model.
module tb_srt4_prenorm_pipe;

  typedef struct packed {
    logic [34:0] dv_star;
    logic [37:0] dd_star;
    logic [4:0]  iters;
    logic [5:0]  rec;
    logic        quo_neg;
    logic        rem_neg;
    logic        dbz;
  } bundle_t;

  localparam int BW = $bits(bundle_t);

  logic clk, rst, flush;
  int   checks, errors, n_in, n_out;
  bit   mon_en, rand_mode;
  logic [BW-1:0] exp_q[$];

  srt4_prenorm_pipe_if #(.DW(32)) bus ();

  srt4_prenorm_pipe #(.DW(32), .SIGNED_EN(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: magnitudes by arithmetic, normalisation from the position of
  // the highest set bit of |divisor|.
  function automatic logic [BW-1:0] model(input logic s, input logic [31:0] dd, input logic [31:0] dv);
    bundle_t b;
    bit      sdd, sdv;
    longint  add, adv;
    int      p, lz;
    b   = '0;
    sdd = s && dd[31];
    sdv = s && dv[31];
    add = longint'(dd);
    adv = longint'(dv);
    if (sdd) add = 64'h1_0000_0000 - add;
    if (sdv) adv = 64'h1_0000_0000 - adv;
    if (adv == 0) begin
      b.dbz = 1'b1;
    end else begin
      p = 0;
      for (int i = 0; i < 32; i++) if (adv >= (64'd1 << i)) p = i;
      lz        = 31 - p;
      b.dv_star = 35'(adv * (64'd1 << lz));
      b.dd_star = 38'((lz % 2 == 0) ? add * 2 : add);
      b.iters   = 5'((lz + 1) / 2 + 1);
      b.rec     = 6'(32 - lz);
      b.quo_neg = sdd ^ sdv;
      b.rem_neg = sdd && (add != 0);
    end
    return b;
  endfunction

  // Scoreboard: compares the presented bundle every cycle it is valid (so a
  // stalled bundle must stay equal to the queue head), pops on transfer.
  always @(negedge clk) begin
    bundle_t e;
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("out_valid_unexpected", 64'(bus.out_valid), 64'(0));
        end else begin
          e = exp_q[0];
          check("divisor_star",  64'(bus.divisor_star),  64'(e.dv_star));
          check("dividend_star", 64'(bus.dividend_star), 64'(e.dd_star));
          check("iterations",    64'(bus.iterations),    64'(e.iters));
          check("recovery",      64'(bus.recovery),      64'(e.rec));
          check("quo_neg",       64'(bus.quo_neg),       64'(e.quo_neg));
          check("rem_neg",       64'(bus.rem_neg),       64'(e.rem_neg));
          check("div_by_zero",   64'(bus.div_by_zero),   64'(e.dbz));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (rst || flush) begin
        exp_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.op_signed, bus.dividend, bus.divisor));
        n_in++;
      end
    end
  end

  task automatic rand_ready();
    if (rand_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one bundle and returns one cycle after it was accepted, with
  // in_valid still high so the next call can go back-to-back.
  task automatic send(input logic s, input logic [31:0] dd, input logic [31:0] dv);
    logic acc;
    acc           = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op_signed = s;
    bus.dividend  = dd;
    bus.divisor   = dv;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
      rand_ready();
    end
    check("accept_timeout", 64'(acc), 64'(1));
    @(posedge clk); #1;
    rand_ready();
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      rand_ready();
    end
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    rand_mode     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"},     64'(bus.out_valid),     64'(0));
    check({tag, "_divisor_star"},  64'(bus.divisor_star),  64'(0));
    check({tag, "_dividend_star"}, 64'(bus.dividend_star), 64'(0));
    check({tag, "_iterations"},    64'(bus.iterations),    64'(0));
    check({tag, "_recovery"},      64'(bus.recovery),      64'(0));
    check({tag, "_flags"},         64'({bus.quo_neg, bus.rem_neg, bus.div_by_zero}), 64'(0));
  endtask

  logic [31:0] dir_dd [10] = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd100, 32'd5,
                               32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFB};
  logic [31:0] dir_dv [10] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0,
                               32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd0};
  logic        dir_s  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int base;
    logic [31:0] dv;
    checks = 0; errors = 0; n_in = 0; n_out = 0;
    mon_en = 1'b0; rand_mode = 1'b0;
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.op_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    bus.out_ready = 1'b0;

    // Reset: in_ready low while reset is sampled, then high with clean outputs.
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check_zero_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check_zero_outputs("post_rst");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed cases, back-to-back with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(dir_s[i], dir_dd[i], dir_dv[i]);
    drain();

    // Three ops against a stalled consumer: two are absorbed, the third waits.
    bus.out_ready = 1'b0;
    base = n_out;
    send(1'b0, 32'd1000, 32'd3);
    send(1'b1, 32'hFFFF_0000, 32'd12345);
    bus.op_signed = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'h0001_0000;
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(1'b0, 32'd77, 32'h0001_0000);
    drain();
    check("stall_delivered", 64'(n_out - base), 64'(3));

    // Flush with both stages full and a new bundle offered in the same cycle.
    bus.out_ready = 1'b0;
    send(1'b0, 32'd9, 32'd2);
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFE);
    bus.dividend = 32'd55; bus.divisor = 32'd5;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_stale", 64'(bus.out_valid), 64'(0));
    send(1'b0, 32'd123, 32'd10);
    drain();

    // Reset mid-operation: nothing partial escapes and data registers clear.
    bus.out_ready = 1'b0;
    send(1'b1, 32'hFFFF_FF00, 32'd3);
    send(1'b0, 32'd4242, 32'd17);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_zero_outputs("mid_rst");
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_stale", 64'(bus.out_valid), 64'(0));

    // Random traffic under random back-pressure and random input gaps.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       dv = 32'd0;
        1, 2:    dv = 32'($urandom_range(1, 255));
        default: dv = $urandom >> $urandom_range(0, 31);
      endcase
      send(1'($urandom_range(0, 1)), $urandom >> $urandom_range(0, 8), dv);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    check("in_out_balance", 64'(n_out), 64'(n_in - 4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
